adaptive_bp_monitor_mc: RTL and testbench

Multi-channel successor to the single-queue telemetry/backpressure monitor. It tracks per-channel queue occupancy from valid/drain events and applies hysteretic congestion detection (high/low thresholds plus a recovery hold time). It drives per-channel backpressure and exports occupancy, peak-level and congestion-event telemetry. It sits between traffic sources and the shared drain scheduler in the telemetry path.

---
 rtl/adaptive_bp_monitor_mc_pkg.sv | 12 +
 rtl/adaptive_bp_monitor_mc_channel.sv | 113 +++++++++++
 rtl/adaptive_bp_monitor_mc.sv | 60 ++++++
 tb/tb_adaptive_bp_monitor_mc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/adaptive_bp_monitor_mc_pkg.sv
// Shared types and defaults for the multi-channel backpressure monitor.
package bp_mon_pkg;

    typedef enum logic [1:0] {
        BP_NORMAL    = 2'd0,
        BP_CONGESTED = 2'd1,
        BP_RECOVER   = 2'd2
    } bp_state_e;

    localparam int BP_EVT_W = 16;

endpackage

// File: rtl/adaptive_bp_monitor_mc_channel.sv
// One channel: occupancy counter, hysteretic congestion FSM with recovery hold,
// peak tracking and saturating congestion-entry counter.
module bp_channel
    import bp_mon_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int HI_TH = 12,
    parameter int LO_TH = 4,
    parameter int HOLD  = 8,
    parameter int EVT_W = BP_EVT_W,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic             drain_i,
    input  logic             clr_stats_i,
    output logic             backpressure_o,
    output logic             congestion_o,
    output logic [LVL_W-1:0] level_o,
    output logic [LVL_W-1:0] peak_o,
    output logic [EVT_W-1:0] events_o
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  HI_L      = LVL_W'(HI_TH);
    localparam logic [LVL_W-1:0]  LO_L      = LVL_W'(LO_TH);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD - 1);

    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic [LVL_W-1:0]  peak_q;
    logic [HOLD_W-1:0] hold_q;
    logic [EVT_W-1:0]  evt_q;
    bp_state_e         state_q;

    logic bp;
    logic accept;
    logic dec;

    // Stalling at DEPTH makes overflow unreachable, so no upper clamp is needed.
    assign bp     = (state_q != BP_NORMAL) || (level_q == DEPTH_L);
    assign accept = in_valid_i & ~bp;
    assign dec    = drain_i & (level_q != '0);

    always_comb begin
        level_d = level_q;
        if (accept && !dec) begin
            level_d = level_q + LVL_W'(1);
        end else if (!accept && dec) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= '0;
            state_q <= BP_NORMAL;
            hold_q  <= '0;
            peak_q  <= '0;
            evt_q   <= '0;
        end else begin
            level_q <= level_d;

            // Transitions look at the registered level, giving one cycle of detection latency.
            case (state_q)
                BP_NORMAL: begin
                    if (level_q >= HI_L) begin
                        state_q <= BP_CONGESTED;
                        if (evt_q != '1) begin
                            evt_q <= evt_q + EVT_W'(1);
                        end
                    end
                end
                BP_CONGESTED: begin
                    if (level_q <= LO_L) begin
                        state_q <= BP_RECOVER;
                        hold_q  <= HOLD_INIT;
                    end
                end
                BP_RECOVER: begin
                    if (level_q >= HI_L) begin
                        state_q <= BP_CONGESTED;
                    end else if (hold_q == '0) begin
                        state_q <= BP_NORMAL;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= BP_NORMAL;
                end
            endcase

            // Clearing wins over a same-cycle event increment.
            if (clr_stats_i) begin
                peak_q <= level_q;
                evt_q  <= '0;
            end else if (level_q > peak_q) begin
                peak_q <= level_q;
            end
        end
    end

    assign backpressure_o = bp;
    assign congestion_o   = (state_q == BP_CONGESTED);
    assign level_o        = level_q;
    assign peak_o         = peak_q;
    assign events_o       = evt_q;

endmodule

// File: rtl/adaptive_bp_monitor_mc.sv
// Multi-channel backpressure monitor: N_CH independent channels with packed
// occupancy, peak and congestion-event telemetry.
module adaptive_bp_monitor_mc
    import bp_mon_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DEPTH = 16,
    parameter int HI_TH = 12,
    parameter int LO_TH = 4,
    parameter int HOLD  = 8,
    parameter int EVT_W = BP_EVT_W,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       drain,
    input  logic                  clr_stats,
    output logic [N_CH-1:0]       backpressure,
    output logic [N_CH-1:0]       congestion,
    output logic                  any_congestion,
    output logic [N_CH*LVL_W-1:0] queue_level,
    output logic [N_CH*LVL_W-1:0] peak_level,
    output logic [N_CH*EVT_W-1:0] cong_events
);

    if (N_CH < 1) begin : g_chk_nch
        $error("adaptive_bp_monitor_mc: N_CH must be at least 1");
    end
    if (!((LO_TH >= 0) && (LO_TH < HI_TH) && (HI_TH <= DEPTH))) begin : g_chk_th
        $error("adaptive_bp_monitor_mc: thresholds must satisfy 0 <= LO_TH < HI_TH <= DEPTH");
    end
    if (HOLD < 1) begin : g_chk_hold
        $error("adaptive_bp_monitor_mc: HOLD must be at least 1");
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        bp_channel #(
            .DEPTH (DEPTH),
            .HI_TH (HI_TH),
            .LO_TH (LO_TH),
            .HOLD  (HOLD),
            .EVT_W (EVT_W)
        ) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .in_valid_i     (in_valid[gi]),
            .drain_i        (drain[gi]),
            .clr_stats_i    (clr_stats),
            .backpressure_o (backpressure[gi]),
            .congestion_o   (congestion[gi]),
            .level_o        (queue_level[gi*LVL_W +: LVL_W]),
            .peak_o         (peak_level[gi*LVL_W +: LVL_W]),
            .events_o       (cong_events[gi*EVT_W +: EVT_W])
        );
    end

    assign any_congestion = |congestion;

endmodule

// File: tb/tb_adaptive_bp_monitor_mc.sv
// Scoreboard bench: a per-channel behavioural model predicts every cycle's
// outputs; a negedge monitor pops and compares against the DUT.
module tb_adaptive_bp_monitor_mc;

    localparam int N_CH    = 4;
    localparam int DEPTH   = 16;
    localparam int HI_TH   = 12;
    localparam int LO_TH   = 4;
    localparam int HOLD    = 8;
    localparam int EVT_W   = 16;
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int EVT_MAX = (1 << EVT_W) - 1;

    localparam int M_NORM = 0;
    localparam int M_CONG = 1;
    localparam int M_REC  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_CH-1:0]       in_valid = '0;
    logic [N_CH-1:0]       drain = '0;
    logic                  clr_stats = 1'b0;
    logic [N_CH-1:0]       backpressure;
    logic [N_CH-1:0]       congestion;
    logic                  any_congestion;
    logic [N_CH*LVL_W-1:0] queue_level;
    logic [N_CH*LVL_W-1:0] peak_level;
    logic [N_CH*EVT_W-1:0] cong_events;

    adaptive_bp_monitor_mc #(
        .N_CH(N_CH), .DEPTH(DEPTH), .HI_TH(HI_TH), .LO_TH(LO_TH), .HOLD(HOLD), .EVT_W(EVT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .drain          (drain),
        .clr_stats      (clr_stats),
        .backpressure   (backpressure),
        .congestion     (congestion),
        .any_congestion (any_congestion),
        .queue_level    (queue_level),
        .peak_level     (peak_level),
        .cong_events    (cong_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH-1:0]       bp;
        logic [N_CH-1:0]       cong;
        logic                  any;
        logic [N_CH*LVL_W-1:0] lvl;
        logic [N_CH*LVL_W-1:0] pk;
        logic [N_CH*EVT_W-1:0] ev;
    } exp_t;

    exp_t sb_q[$];

    // Model state: recovery is tracked as elapsed cycles in RECOVER.
    int m_lvl[N_CH];
    int m_mode[N_CH];
    int m_age[N_CH];
    int m_peak[N_CH];
    int m_evt[N_CH];

    int tests = 0;
    int fails = 0;
    int txn = 0;
    bit rec_en = 1'b0;
    int rec_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic bit m_bp(input int c);
        return (m_mode[c] != M_NORM) || (m_lvl[c] == DEPTH);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_lvl[c] = 0; m_mode[c] = M_NORM; m_age[c] = 0; m_peak[c] = 0; m_evt[c] = 0;
        end
    endtask

    task automatic model_step(input logic [N_CH-1:0] iv, input logic [N_CH-1:0] dr, input logic cl);
        for (int c = 0; c < N_CH; c++) begin
            int lv;
            bit acc;
            bit dec;
            lv  = m_lvl[c];
            acc = iv[c] && !m_bp(c);
            dec = dr[c] && (lv > 0);
            if (m_mode[c] == M_NORM) begin
                if (lv >= HI_TH) begin
                    m_mode[c] = M_CONG;
                    if (m_evt[c] < EVT_MAX) m_evt[c]++;
                end
            end else if (m_mode[c] == M_CONG) begin
                if (lv <= LO_TH) begin
                    m_mode[c] = M_REC;
                    m_age[c]  = 0;
                end
            end else begin
                if (lv >= HI_TH) m_mode[c] = M_CONG;
                else if (m_age[c] == HOLD - 1) m_mode[c] = M_NORM;
                else m_age[c]++;
            end
            if (cl) begin
                m_peak[c] = lv;
                m_evt[c]  = 0;
            end else if (lv > m_peak[c]) begin
                m_peak[c] = lv;
            end
            m_lvl[c] = lv + int'(acc) - int'(dec);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.bp = '0; e.cong = '0; e.lvl = '0; e.pk = '0; e.ev = '0;
        for (int c = 0; c < N_CH; c++) begin
            e.bp[c]   = m_bp(c);
            e.cong[c] = (m_mode[c] == M_CONG);
            e.lvl[c*LVL_W +: LVL_W] = LVL_W'(m_lvl[c]);
            e.pk[c*LVL_W +: LVL_W]  = LVL_W'(m_peak[c]);
            e.ev[c*EVT_W +: EVT_W]  = EVT_W'(m_evt[c]);
        end
        e.any = |e.cong;
        return e;
    endfunction

    // Push the expectation for the state just clocked, then apply new inputs.
    task automatic step_cycle(input logic r, input logic [N_CH-1:0] iv,
                              input logic [N_CH-1:0] dr, input logic cl);
        @(posedge clk);
        #1;
        sb_q.push_back(snapshot());
        rst_n = r; in_valid = iv; drain = dr; clr_stats = cl;
        if (!r) model_reset();
        else model_step(iv, dr, cl);
    endtask

    always @(negedge clk) begin
        if (rec_en && backpressure[0] && !congestion[0]) rec_cnt++;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("backpressure", 64'(backpressure), 64'(e.bp));
                chk("congestion", 64'(congestion), 64'(e.cong));
                chk("any_congestion", 64'(any_congestion), 64'(e.any));
                chk("queue_level", 64'(queue_level), 64'(e.lvl));
                chk("peak_level", 64'(peak_level), 64'(e.pk));
                chk("cong_events", 64'(cong_events), 64'(e.ev));
                chk("cong_implies_bp", 64'(congestion & ~backpressure), 64'd0);
                $display("[TB] txn %0d lvl=%h pk=%h bp=%b cong=%b ev=%h",
                         txn, queue_level, peak_level, backpressure, congestion, cong_events);
                txn++;
            end
        end
    end

    initial begin : driver
        logic [N_CH-1:0] iv;
        logic [N_CH-1:0] dr;
        model_reset();

        repeat (5) step_cycle(1'b0, '1, '0, 1'b0);
        chk("rst_levels", 64'(queue_level), 64'd0);
        chk("rst_bp", 64'(backpressure), 64'd0);
        repeat (3) step_cycle(1'b1, '1, '0, 1'b0);
        repeat (2) step_cycle(1'b0, '1, '0, 1'b0);

        repeat (16) step_cycle(1'b1, 4'b0001, '0, 1'b0);
        step_cycle(1'b1, '0, '0, 1'b0);
        chk("fill_level0", 64'(queue_level[LVL_W-1:0]), 64'd13);
        chk("fill_cong0", 64'(congestion[0]), 64'd1);
        chk("fill_evt0", 64'(cong_events[EVT_W-1:0]), 64'd1);

        // Drain while still requesting: arrivals stay blocked through RECOVER.
        rec_en = 1'b1;
        repeat (10) step_cycle(1'b1, 4'b0001, 4'b0001, 1'b0);
        repeat (14) step_cycle(1'b1, '0, '0, 1'b0);
        rec_en = 1'b0;
        chk("recover_len", 64'(rec_cnt), 64'd8);
        chk("evt_after_recover", 64'(cong_events[EVT_W-1:0]), 64'd1);

        step_cycle(1'b1, '0, '0, 1'b1);
        step_cycle(1'b1, '0, '0, 1'b0);
        chk("clr_peak0", 64'(peak_level[LVL_W-1:0]), 64'd3);
        chk("clr_evt0", 64'(cong_events[EVT_W-1:0]), 64'd0);

        repeat (5) step_cycle(1'b1, 4'b0100, '0, 1'b0);
        repeat (4) step_cycle(1'b1, 4'b0100, 4'b0100, 1'b0);
        step_cycle(1'b1, '0, '0, 1'b0);
        chk("ch2_hold5", 64'(queue_level[2*LVL_W +: LVL_W]), 64'd5);
        repeat (7) step_cycle(1'b1, '0, 4'b0100, 1'b0);
        step_cycle(1'b1, '0, '0, 1'b0);
        chk("ch2_floor0", 64'(queue_level[2*LVL_W +: LVL_W]), 64'd0);
        chk("ch0_unaffected", 64'(queue_level[LVL_W-1:0]), 64'd3);

        // Alternating fill-heavy and drain-heavy blocks to cycle through all states.
        for (int blk = 0; blk < 40; blk++) begin
            for (int k = 0; k < 40; k++) begin
                if (blk % 2 == 0) begin
                    iv = N_CH'($urandom | $urandom);
                    dr = N_CH'($urandom & $urandom & $urandom);
                end else begin
                    iv = N_CH'($urandom & $urandom);
                    dr = N_CH'($urandom | $urandom);
                end
                step_cycle(($urandom_range(0, 499) != 0), iv, dr, ($urandom_range(0, 63) == 0));
            end
        end

        step_cycle(1'b1, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
